// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the multi-cycle ALU units: FSM state
//            encoding and the chunk-count / counter-width derivations.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // State encoding shared by the multi-cycle ALU units.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int alu_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk-counter width; never narrower than one bit so a single-chunk
  // configuration still gets a legal vector.
  function automatic int alu_cnt_w(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunk_adder
// Purpose  : Combinational CHUNK-bit adder with carry in and carry out.
// Ports    : a_i, b_i  - CHUNK-bit addends
//            c_i       - carry in
//            s_o       - CHUNK-bit sum
//            c_o       - carry out
// Revision : 1.0 - initial release
// ============================================================================
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);

  // One extra bit on each addend captures the carry out of the slice.
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};

endmodule : chunk_adder
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder
// Purpose  : Multi-cycle add/subtract unit. Processes WIDTH-bit operands
//            CHUNK bits per clock, carrying the partial carry across cycles,
//            with valid/ready handshakes on input and output.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid / in_ready - operand handshake
//            e, f                - operands A and B
//            carry_in            - carry-in (add) / borrow-in (sub)
//            sub                 - 0: e+f+carry_in, 1: e-f-carry_in
//            out_valid/out_ready - result handshake
//            sum                 - WIDTH-bit result (modulo 2^WIDTH)
//            carry_out           - add: carry out; sub: 1 = no borrow
//            overflow            - two's-complement signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module seq_chunk_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = alu_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = alu_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  // Elaboration-time parameter sanity checks.
  if ((CHUNK < 1) || (WIDTH % CHUNK != 0) || (NCHUNK < 1)) begin : g_param_check
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  alu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] e_q,     e_d;
  logic [WIDTH-1:0] f_q,     f_d;     // f, already inverted for subtract
  logic             c_q,     c_d;     // running carry between chunks
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_co;

  assign chunk_a = e_q[int'(cnt_q) * CHUNK +: CHUNK];
  assign chunk_b = f_q[int'(cnt_q) * CHUNK +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a_i (chunk_a),
    .b_i (chunk_b),
    .c_i (c_q),
    .s_o (chunk_s),
    .c_o (chunk_co)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    e_d       = e_q;
    f_d       = f_q;
    c_d       = c_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtract is e + ~f + ~borrow; carry out then means "no borrow".
          e_d     = e;
          f_d     = sub ? ~f : f;
          c_d     = carry_in ^ sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        sum_d[int'(cnt_q) * CHUNK +: CHUNK] = chunk_s;
        c_d = chunk_co;
        if (cnt_q == LAST_CHUNK) begin
          cout_d  = chunk_co;
          // Same-sign operands producing an opposite-sign result.
          ovf_d   = (e_q[WIDTH-1] == f_q[WIDTH-1]) &&
                    (sum_d[WIDTH-1] != e_q[WIDTH-1]);
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      e_q     <= '0;
      f_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      f_q     <= f_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule : seq_chunk_adder
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_chunk_adder
// Purpose  : Self-checking bench for seq_chunk_adder (WIDTH=8, CHUNK=2).
//            Expected results come from integer arithmetic on the operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder;

  localparam int W      = 8;
  localparam int C      = 2;
  localparam int N      = W / C;
  localparam int BUDGET = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] e;
  logic [W-1:0] f;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int passes = 0;

  seq_chunk_adder #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .e         (e),
    .f         (f),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: unsigned result for sum/carry, signed result for
  // overflow, both taken straight from the operation's definition.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic ci, input logic s,
                                    output logic [W-1:0] r_sum,
                                    output logic r_co, output logic r_ov);
    int ua, ub, sa, sb, u, sr;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    if (!s) begin
      u    = ua + ub + int'(ci);
      sr   = sa + sb + int'(ci);
      r_co = (u >= (1 << W));
    end else begin
      u    = ua - ub - int'(ci);
      sr   = sa - sb - int'(ci);
      r_co = (u >= 0);
    end
    r_sum = u[W-1:0];
    r_ov  = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
  endfunction

  // Drives one full operation, scrambling the operand inputs after the
  // accept edge, and returns the result and the accept-to-valid latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic s,
                        output logic [W-1:0] r_sum, output logic r_co,
                        output logic r_ov, output int lat, output bit timed_out);
    int w;
    w = 0;
    timed_out = 1'b0;
    while (!in_ready && w < BUDGET) begin
      step();
      w++;
    end
    e = a; f = b; carry_in = ci; sub = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    e = W'($urandom); f = W'($urandom);
    carry_in = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < BUDGET) begin
      step();
      lat++;
    end
    if (!out_valid) timed_out = 1'b1;
    r_sum = sum; r_co = carry_out; r_ov = overflow;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    e = '0; f = '0; carry_in = 1'b0; sub = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (sum !== 8'h00) $display("FAIL reset_sum got=%h exp=00", sum); else passes++;
    checks++; if (carry_out !== 1'b0) $display("FAIL reset_carry_out got=%b exp=0", carry_out); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else passes++;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_idle_hold got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    else passes++;
  endtask

  task automatic test_directed();
    logic [W-1:0] ve [5] = '{8'h07, 8'hFF, 8'h05, 8'h80, 8'h7F};
    logic [W-1:0] vf [5] = '{8'h06, 8'h01, 8'h07, 8'h01, 8'h01};
    logic         vc [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic         vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] xs [5] = '{8'h0E, 8'h00, 8'hFE, 8'h7F, 8'h80};
    logic         xc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         xo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] r_sum;
    logic r_co, r_ov;
    int lat;
    bit to;
    for (int i = 0; i < 5; i++) begin
      run_op(ve[i], vf[i], vc[i], vs[i], r_sum, r_co, r_ov, lat, to);
      checks++; if (to) $display("FAIL directed%0d_timeout no out_valid within %0d cycles", i, BUDGET); else passes++;
      checks++; if (lat != N) $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, N); else passes++;
      checks++; if (r_sum !== xs[i]) $display("FAIL directed%0d_sum got=%h exp=%h", i, r_sum, xs[i]); else passes++;
      checks++; if (r_co !== xc[i]) $display("FAIL directed%0d_carry got=%b exp=%b", i, r_co, xc[i]); else passes++;
      checks++; if (r_ov !== xo[i]) $display("FAIL directed%0d_overflow got=%b exp=%b", i, r_ov, xo[i]); else passes++;
    end
  endtask

  task automatic test_backpressure();
    int w;
    w = 0;
    while (!in_ready && w < BUDGET) begin step(); w++; end
    e = 8'h12; f = 8'h34; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < BUDGET) begin step(); w++; end
    checks++; if (!out_valid) $display("FAIL bp_reach_done out_valid=%b exp=1", out_valid); else passes++;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; e = 8'hAA; f = 8'h55; sub = 1'b1; carry_in = 1'b1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d_handshake got vld=%b rdy=%b exp vld=1 rdy=0", i, out_valid, in_ready);
      else passes++;
      checks++; if (sum !== 8'h46 || carry_out !== 1'b0 || overflow !== 1'b0)
        $display("FAIL bp_hold%0d_outputs got sum=%h co=%b ov=%b exp sum=46 co=0 ov=0", i, sum, carry_out, overflow);
      else passes++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    else passes++;
    checks++; if (sum !== 8'h46) $display("FAIL bp_idle_sum_held got=%h exp=46", sum); else passes++;
    step();
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_no_ghost_op got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r_sum;
    logic r_co, r_ov;
    int lat, w;
    bit to, seen;
    w = 0;
    while (!in_ready && w < BUDGET) begin step(); w++; end
    e = 8'h55; f = 8'h66; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midrst_state got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    else passes++;
    checks++; if (sum !== 8'h00 || carry_out !== 1'b0 || overflow !== 1'b0)
      $display("FAIL midrst_outputs got sum=%h co=%b ov=%b exp 00/0/0", sum, carry_out, overflow);
    else passes++;
    seen = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL midrst_discard got out_valid=1 exp=0"); else passes++;
    run_op(8'h03, 8'h04, 1'b0, 1'b0, r_sum, r_co, r_ov, lat, to);
    checks++; if (to || r_sum !== 8'h07 || r_co !== 1'b0 || r_ov !== 1'b0)
      $display("FAIL midrst_next_op got sum=%h co=%b ov=%b to=%b exp sum=07 co=0 ov=0", r_sum, r_co, r_ov, to);
    else passes++;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r_sum, x_sum;
    logic ci, s, r_co, r_ov, x_co, x_ov;
    int lat;
    bit to;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom); b = W'($urandom);
      ci = 1'($urandom); s = 1'($urandom);
      if (i < 2) begin a = 8'h80; b = 8'h80; end
      ref_model(a, b, ci, s, x_sum, x_co, x_ov);
      run_op(a, b, ci, s, r_sum, r_co, r_ov, lat, to);
      checks++; if (to || lat != N) $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, N); else passes++;
      checks++; if (r_sum !== x_sum) $display("FAIL rand%0d_sum a=%h b=%h ci=%b sub=%b got=%h exp=%h", i, a, b, ci, s, r_sum, x_sum); else passes++;
      checks++; if (r_co !== x_co) $display("FAIL rand%0d_carry a=%h b=%h ci=%b sub=%b got=%b exp=%b", i, a, b, ci, s, r_co, x_co); else passes++;
      checks++; if (r_ov !== x_ov) $display("FAIL rand%0d_overflow a=%h b=%h ci=%b sub=%b got=%b exp=%b", i, a, b, ci, s, r_ov, x_ov); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q_sum [$];
    logic         q_co  [$];
    logic         q_ov  [$];
    int           acc   [$];
    logic [W-1:0] x_sum, ps;
    logic x_co, x_ov, pc, po;
    int w;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4 * (N + 2); cyc++) begin
      if (out_valid) begin
        checks++;
        if (q_sum.size() == 0) $display("FAIL b2b_unexpected_result at cycle %0d", cyc);
        else begin
          ps = q_sum.pop_front(); pc = q_co.pop_front(); po = q_ov.pop_front();
          if (sum !== ps || carry_out !== pc || overflow !== po)
            $display("FAIL b2b_result got sum=%h co=%b ov=%b exp sum=%h co=%b ov=%b", sum, carry_out, overflow, ps, pc, po);
          else passes++;
        end
      end
      e = W'($urandom); f = W'($urandom);
      carry_in = 1'($urandom); sub = 1'($urandom);
      if (in_ready) begin
        ref_model(e, f, carry_in, sub, x_sum, x_co, x_ov);
        q_sum.push_back(x_sum); q_co.push_back(x_co); q_ov.push_back(x_ov);
        acc.push_back(cyc);
      end
      step();
    end
    in_valid = 1'b0;
    w = 0;
    while (q_sum.size() != 0 && w < BUDGET) begin
      if (out_valid) begin
        ps = q_sum.pop_front(); pc = q_co.pop_front(); po = q_ov.pop_front();
        checks++;
        if (sum !== ps || carry_out !== pc || overflow !== po)
          $display("FAIL b2b_drain got sum=%h co=%b ov=%b exp sum=%h co=%b ov=%b", sum, carry_out, overflow, ps, pc, po);
        else passes++;
      end
      step();
      w++;
    end
    out_ready = 1'b0;
    checks++; if (q_sum.size() != 0) $display("FAIL b2b_missing_results got=%0d pending exp=0", q_sum.size()); else passes++;
    checks++; if (acc.size() != 4) $display("FAIL b2b_accept_count got=%0d exp=4", acc.size()); else passes++;
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != N + 2)
        $display("FAIL b2b_interval%0d got=%0d exp=%0d", i, acc[i] - acc[i-1], N + 2);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_seq_chunk_adder
`default_nettype wire
